pixel_byte_serializer: RTL
==========================

Name: pixel_byte_serializer

Overview:
Splits 24-bit RGB pixel words into a stream of 8-bit bytes for byte-wide sinks such as a UART, SPI or frame-buffer byte port. It is the inverse of the byte-to-pixel packing used in the VGA path. Upstream and downstream sides each use a valid/ready handshake. The block holds one word and emits its bytes one per accepted transfer, with first/last markers.

Parameters:
NUM_BYTES, 3, bytes per input word; legal range 2..8.
BYTE_W, 8, width of one output byte.
MSB_FIRST, 1, 1 = most-significant byte emitted first; 0 = least-significant byte first.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  synchronous reset, active-high.
in_data  input  NUM_BYTES*BYTE_W  pixel word, e.g. {R,G,B}.
in_valid  input  1  upstream word present.
in_ready  output  1  block can accept a word this cycle.
out_data  output  BYTE_W  current byte.
out_valid  output  1  out_data is valid.
out_ready  input  1  downstream accepts the byte this cycle.
out_first  output  1  out_data is byte 0 of its word.
out_last  output  1  out_data is byte NUM_BYTES-1 of its word.
busy  output  1  a word is held (equals out_valid).

Behaviour:
- Clock, reset and handshake rules:
  - Single clock domain. A transfer occurs on an edge where valid && ready.
  - Reset is synchronous and active-high. While rst is high, in_ready=0. At the edge with rst high: out_valid=0, out_data=0, out_first=0, out_last=0, busy=0, byte index=0, holding register=0.
- State machine, two states:
  - IDLE: out_valid=0, in_ready=1.
    - On in_valid, latch in_data into the holding register, set index=0, go to SEND.
  - SEND: out_valid=1, out_data = byte[index] of the held word.
    - MSB_FIRST=1: byte 0 = bits [NUM_BYTES*BYTE_W-1 -: BYTE_W].
    - MSB_FIRST=0: byte 0 = bits [BYTE_W-1:0].
    - out_first = (index==0); out_last = (index==NUM_BYTES-1).
    - On out_ready with index<NUM_BYTES-1: index increments by 1.
    - On out_ready with index==NUM_BYTES-1 (last byte accepted):
      - If in_valid: load the new word, index=0, stay in SEND. This gives zero bubble cycles between words.
      - Otherwise: go to IDLE, index=0.
- in_ready = !rst && (IDLE || (SEND && out_last && out_ready)). This is a combinational path from out_ready to in_ready, which is permitted.
- Latency: a word accepted at edge N presents its first byte as out_valid from cycle N+1. A NUM_BYTES-byte word occupies exactly NUM_BYTES cycles under continuous out_ready.
- Backpressure: while out_valid && !out_ready, out_data, out_first, out_last and the index hold stable. The held word is never overwritten.
- in_data is sampled only on an input transfer. Changes at other times have no effect.
- Index arithmetic: the counter is $clog2(NUM_BYTES) bits wide and never exceeds NUM_BYTES-1. It has no wrap-around beyond the last byte; the last byte always forces a reload or a return to IDLE.
- Reset mid-word: remaining bytes are discarded. No partial output follows reset. The first transfer after reset starts a fresh word with out_first=1.
- in_valid while in SEND and not on the last-byte transfer: no acceptance, because in_ready=0. The word remains pending upstream.

Test Plan:
- Single word: reset, in_data=0xA1B2C3 with in_valid for 1 cycle, out_ready=1 -> out_data A1 (first=1), B2, C3 (last=1) on 3 consecutive cycles, starting 1 cycle after acceptance; then out_valid=0.
- Back-to-back: 0x112233 then 0x445566 held valid, out_ready=1 -> 11,22,33,44,55,66 on 6 consecutive cycles. in_ready pulses high exactly on the cycle 33 is accepted.
- Backpressure: word 0xA1B2C3; out_ready low for 4 cycles while B2 is presented -> out_data stays B2 with last=0 for all 4 cycles. C3 follows 1 cycle after out_ready rises. in_ready stays 0 throughout.
- Reset mid-word: assert rst after A1 is accepted -> next edge out_valid=0. A following word 0x0F0E0D emits 0F (first=1), 0E, 0D; the stale B2/C3 never appear.
- MSB_FIRST=0: 0xA1B2C3 -> C3 (first), B2, A1 (last).
- NUM_BYTES=4: 0xDEADBEEF -> DE, AD, BE, EF, with last=1 only on EF.

Source files
------------

// File: rtl/pixel_byte_serializer.sv
// Pixel word to byte stream serializer with valid/ready on both sides.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_ready upstream word;
//   out_data/out_valid/out_ready/out_first/out_last downstream byte; busy = word held.
module pixel_byte_serializer #(
    parameter int NUM_BYTES = 3,
    parameter int BYTE_W    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_BYTES*BYTE_W-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [BYTE_W-1:0]           out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_first,
    output logic                        out_last,
    output logic                        busy
);

    localparam int W  = NUM_BYTES * BYTE_W;
    localparam int IW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t          state;
    state_t          state_n;
    logic [W-1:0]    hold;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   idx_n;
    logic [IW-1:0]   sel;
    logic            load;
    logic            at_last;

    assign at_last = (idx == LAST);

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        load      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid) begin
                    load    = 1'b1;
                    idx_n   = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (at_last) begin
                        // Last byte leaving: reload in the same
                        // cycle so words stream with no bubble.
                        in_ready = !rst;
                        idx_n    = '0;
                        if (in_valid) begin
                            load = 1'b1;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign out_first = out_valid && (idx == '0);
    assign out_last  = out_valid && at_last;
    assign busy      = out_valid;

    // Byte position inside the held word for the current index.
    assign sel = MSB_FIRST ? (LAST - idx) : idx;

    always_comb begin
        out_data = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            if (sel == IW'(i)) begin
                out_data = hold[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            hold  <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (load) begin
                hold <= in_data;
            end
        end
    end

endmodule
